// File: rtl/scale_controller_if.sv
// Scale controller bus: raster/button inputs toward the controller and
// scale/address outputs back toward the frame-buffer read side.
// Optional macro SCALE_DOWN_BTN_EN adds the btn_down_in member.
interface scale_controller_if #(
  parameter int ADDR_W = 17
);
  logic              btn_in;
`ifdef SCALE_DOWN_BTN_EN
  logic              btn_down_in;
`endif
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic              active_draw_in;
  logic              new_frame_in;
  logic [1:0]        scale_out;
  logic              change_pending_out;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid_out;

`ifdef SCALE_DOWN_BTN_EN
  modport master (
    output btn_in, btn_down_in, hcount_in, vcount_in, active_draw_in, new_frame_in,
    input  scale_out, change_pending_out, addr_out, addr_valid_out
  );
  modport slave (
    input  btn_in, btn_down_in, hcount_in, vcount_in, active_draw_in, new_frame_in,
    output scale_out, change_pending_out, addr_out, addr_valid_out
  );
`else
  modport master (
    output btn_in, hcount_in, vcount_in, active_draw_in, new_frame_in,
    input  scale_out, change_pending_out, addr_out, addr_valid_out
  );
  modport slave (
    input  btn_in, hcount_in, vcount_in, active_draw_in, new_frame_in,
    output scale_out, change_pending_out, addr_out, addr_valid_out
  );
`endif
endinterface

// File: rtl/scale_controller.sv
// Display scale controller: steps the scale 1x/2x/4x on button presses,
// applies a pending change only at a frame boundary, and turns raster
// counters into frame-buffer read addresses through a 2-stage pipeline.
// Optional macro SCALE_DOWN_BTN_EN adds a scale-down button (btn_down_in).
module scale_controller #(
  parameter int FB_WIDTH      = 240,
  parameter int FB_HEIGHT     = 320,
  parameter int STARTUP_SCALE = 0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  scale_controller_if.slave bus
);

  localparam int ADDR_W = $clog2(FB_WIDTH * FB_HEIGHT);
  localparam logic [1:0]        START   = 2'(STARTUP_SCALE);
  localparam logic [10:0]       W_LIMIT = 11'(FB_WIDTH);
  localparam logic [9:0]        H_LIMIT = 10'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] W_ADDR  = ADDR_W'(FB_WIDTH);

  typedef enum logic {
    STABLE,
    PENDING
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        scale;
  logic [1:0]        scale_next;
  logic [1:0]        pending;
  logic [1:0]        pending_next;
  logic              btn_prev;
  logic              press;
`ifdef SCALE_DOWN_BTN_EN
  logic              btn_down_prev;
  logic              down_press;
`endif

  logic [10:0]       h_shift;
  logic [9:0]        v_shift;
  logic [10:0]       sh;
  logic [9:0]        sv;
  logic              v1;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;

  // Scale code sequence 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] step_up(input logic [1:0] code);
    return (code == 2'd2) ? 2'd0 : code + 2'd1;
  endfunction

  // Scale code sequence 2 -> 1 -> 0 -> 2.
  function automatic logic [1:0] step_down(input logic [1:0] code);
    return (code == 2'd0) ? 2'd2 : code - 2'd1;
  endfunction

  // Control registers; button history resets high so a held button is not a press.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= STABLE;
      scale         <= START;
      pending       <= START;
      btn_prev      <= 1'b1;
`ifdef SCALE_DOWN_BTN_EN
      btn_down_prev <= 1'b1;
`endif
    end else begin
      state         <= state_next;
      scale         <= scale_next;
      pending       <= pending_next;
      btn_prev      <= bus.btn_in;
`ifdef SCALE_DOWN_BTN_EN
      btn_down_prev <= bus.btn_down_in;
`endif
    end
  end

  // Next pending/applied scale; the frame boundary applies the pre-press pending value.
  always_comb begin
    press        = bus.btn_in & ~btn_prev;
    pending_next = pending;
`ifdef SCALE_DOWN_BTN_EN
    down_press   = bus.btn_down_in & ~btn_down_prev;
    if (press && !down_press) begin
      pending_next = step_up(pending);
    end else if (down_press && !press) begin
      pending_next = step_down(pending);
    end
`else
    if (press) begin
      pending_next = step_up(pending);
    end
`endif
    scale_next = bus.new_frame_in ? pending : scale;
    state_next = (pending_next != scale_next) ? PENDING : STABLE;
  end

  assign bus.scale_out          = scale;
  assign bus.change_pending_out = (state == PENDING);

  assign h_shift = bus.hcount_in >> scale;
  assign v_shift = bus.vcount_in >> scale;

  // Two-stage address pipeline: scale the raster position, then linearise it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sh         <= '0;
      sv         <= '0;
      v1         <= 1'b0;
      addr       <= '0;
      addr_valid <= 1'b0;
    end else begin
      sh         <= h_shift;
      sv         <= v_shift;
      v1         <= bus.active_draw_in && (h_shift < W_LIMIT) && (v_shift < H_LIMIT);
      addr       <= v1 ? (ADDR_W'(sv) * W_ADDR + ADDR_W'(sh)) : '0;
      addr_valid <= v1;
    end
  end

  assign bus.addr_out       = addr;
  assign bus.addr_valid_out = addr_valid;

endmodule

// File: tb/tb_scale_controller.sv
// Scoreboard bench for scale_controller: a reference model predicts scale,
// change-pending and address results; a monitor compares them as they appear.
module tb_scale_controller;

  localparam int FB_WIDTH      = 240;
  localparam int FB_HEIGHT     = 320;
  localparam int STARTUP_SCALE = 0;
  localparam int ADDR_W        = 17;

  typedef struct {
    int due;
    int scale;
    int cp;
  } ctrl_t;

  typedef struct {
    int due;
    int addr;
    int valid;
  } addr_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  ctrl_t ctrl_q[$];
  addr_t addr_q[$];

  int edge_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  int m_scale   = STARTUP_SCALE;
  int m_pending = STARTUP_SCALE;
  int m_prev    = 1;

  scale_controller_if #(.ADDR_W(ADDR_W)) bus ();

  scale_controller #(
    .FB_WIDTH     (FB_WIDTH),
    .FB_HEIGHT    (FB_HEIGHT),
    .STARTUP_SCALE(STARTUP_SCALE)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // Count rising edges so expectations can be tied to the edge that produces them.
  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and let the model predict what the DUT must show.
  task automatic applyStimulus(input bit rst, input bit btn, input bit nf,
                               input bit act, input int h, input int v);
    int    n;
    int    sh;
    int    sv;
    int    press;
    int    new_scale;
    addr_t a;
    ctrl_t c;
    @(negedge clk_in);
    #1;
    rst_in             = rst;
    bus.btn_in         = btn;
    bus.new_frame_in   = nf;
    bus.active_draw_in = act;
    bus.hcount_in      = 11'(h);
    bus.vcount_in      = 10'(v);
    n = edge_cnt + 1;

    sh = h / (1 << m_scale);
    sv = v / (1 << m_scale);
    a.due = n + 1;
    if (!rst && act && sh < FB_WIDTH && sv < FB_HEIGHT) begin
      a.valid = 1;
      a.addr  = sv * FB_WIDTH + sh;
    end else begin
      a.valid = 0;
      a.addr  = 0;
    end

    if (rst) begin
      if (addr_q.size() > 0 && addr_q[addr_q.size()-1].due == n) begin
        addr_t last;
        last = addr_q.pop_back();
        last.valid = 0;
        last.addr  = 0;
        addr_q.push_back(last);
      end
      m_scale   = STARTUP_SCALE;
      m_pending = STARTUP_SCALE;
      m_prev    = 1;
    end else begin
      press     = (btn && m_prev == 0) ? 1 : 0;
      new_scale = nf ? m_pending : m_scale;
      if (press == 1) m_pending = (m_pending + 1) % 3;
      m_scale = new_scale;
      m_prev  = btn ? 1 : 0;
    end
    c.due   = n;
    c.scale = m_scale;
    c.cp    = (m_pending != m_scale) ? 1 : 0;
    ctrl_q.push_back(c);
    addr_q.push_back(a);
  endtask

  // Monitor: pop expectations that fall due and compare them with the DUT outputs.
  always @(negedge clk_in) begin
    ctrl_t c;
    addr_t a;
    while (ctrl_q.size() > 0 && ctrl_q[0].due <= edge_cnt) begin
      c = ctrl_q.pop_front();
      if (c.due < edge_cnt) begin
        checkOutput("ctrl_due", edge_cnt, c.due);
      end else begin
        checkOutput("scale", int'(bus.scale_out), c.scale);
        checkOutput("change_pending", int'(bus.change_pending_out), c.cp);
      end
    end
    while (addr_q.size() > 0 && addr_q[0].due <= edge_cnt) begin
      a = addr_q.pop_front();
      if (a.due < edge_cnt) begin
        checkOutput("addr_due", edge_cnt, a.due);
      end else begin
        checkOutput("addr_valid", int'(bus.addr_valid_out), a.valid);
        checkOutput("addr", int'(bus.addr_out), a.addr);
      end
    end
  end

  // Directed scenarios, then a randomized run, then a bounded drain and summary.
  initial begin
    int wait_cycles;
    bus.btn_in         = 1'b1;
    bus.new_frame_in   = 1'b0;
    bus.active_draw_in = 1'b0;
    bus.hcount_in      = '0;
    bus.vcount_in      = '0;
`ifdef SCALE_DOWN_BTN_EN
    bus.btn_down_in    = 1'b0;
`endif

    // reset with the button held high through release
    repeat (3) applyStimulus(1, 1, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // scale 0 addressing
    applyStimulus(0, 0, 0, 1, 5, 2);
    applyStimulus(0, 0, 0, 1, 240, 2);
    applyStimulus(0, 0, 0, 1, 239, 319);

    // single press mid-frame, applied at the next frame boundary
    applyStimulus(0, 1, 0, 1, 10, 10);
    applyStimulus(0, 0, 0, 1, 11, 10);
    applyStimulus(0, 0, 1, 1, 12, 10);
    applyStimulus(0, 0, 0, 1, 479, 639);
    applyStimulus(0, 0, 0, 1, 480, 639);
    applyStimulus(0, 0, 0, 1, 479, 640);

    // one more press to reach scale 2
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1279, 719);
    applyStimulus(0, 0, 0, 1, 959, 719);

    // three presses in one frame wrap pending back to the applied scale
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, i * 100, i * 50);
      applyStimulus(0, 0, 0, 1, i * 100 + 1, i * 50);
    end
    applyStimulus(0, 0, 1, 1, 40, 40);
    applyStimulus(0, 0, 0, 1, 40, 40);

    // get to scale 0 with pending 1, then press on the frame pulse
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 100, 100);
    applyStimulus(0, 0, 0, 1, 100, 100);

    // reset mid-stream
    applyStimulus(0, 0, 0, 1, 20, 20);
    applyStimulus(1, 0, 0, 1, 20, 20);
    applyStimulus(0, 0, 0, 1, 20, 20);
    applyStimulus(0, 0, 0, 1, 21, 20);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int h;
      int v;
      if ($urandom_range(0, 9) == 0) begin
        h = $urandom_range(0, 2047);
        v = $urandom_range(0, 1023);
      end else begin
        h = $urandom_range(0, 1279);
        v = $urandom_range(0, 719);
      end
      applyStimulus(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                    h, v);
    end

    wait_cycles = 0;
    while ((ctrl_q.size() > 0 || addr_q.size() > 0) && wait_cycles < 10) begin
      @(negedge clk_in);
      wait_cycles++;
    end
    @(posedge clk_in);
    if (ctrl_q.size() > 0 || addr_q.size() > 0) begin
      checkOutput("drain", ctrl_q.size() + addr_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
